// File: rtl/compare8_checker.sv
// Self-checking stimulus/response engine for an 8-bit magnitude comparator.
// Drives a/b from a seeded LFSR, checks re/reb/eq against a golden compare,
// and reports vector/error counts plus the first failing operand pair.
module compare8_checker #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  a,
    output logic [7:0]  b,
    input  logic        re,
    input  logic        reb,
    input  logic        eq,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] vec_count,
    output logic [7:0]  err_count,
    output logic [7:0]  first_err_a,
    output logic [7:0]  first_err_b
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned LW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   lfsr, lfsr_nxt, lfsr_step_c;
    logic [DW-1:0]   a_nxt, b_nxt, fea_nxt, feb_nxt, err_nxt;
    logic [CW-1:0]   vec_nxt;
    logic            busy_nxt, done_nxt, pass_nxt;
    logic            mismatch_c;

    // Fibonacci LFSR successor of the current state
    always_comb begin
        lfsr_step_c = {lfsr[LW-2:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Compare observed comparator outputs with the golden triple for current a/b
    always_comb begin
        mismatch_c = ({re, reb, eq} != {a > b, a < b, a == b});
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        a_nxt     = a;
        b_nxt     = b;
        vec_nxt   = vec_count;
        err_nxt   = err_count;
        fea_nxt   = first_err_a;
        feb_nxt   = first_err_b;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    lfsr_nxt  = SEED;
                    // vector 0 is deliberately an equality case
                    a_nxt     = SEED[15:8];
                    b_nxt     = SEED[15:8];
                    vec_nxt   = '0;
                    err_nxt   = '0;
                    fea_nxt   = '0;
                    feb_nxt   = '0;
                end
            end
            RUN: begin
                if (mismatch_c) begin
                    if (err_count != 8'hFF) begin
                        err_nxt = err_count + 8'd1;
                    end
                    if (err_count == 8'h00) begin
                        fea_nxt = a;
                        feb_nxt = b;
                    end
                end
                vec_nxt = vec_count + 16'd1;
                if (vec_nxt == CW'(NUM_VECTORS)) begin
                    state_nxt = DONE;
                end else begin
                    lfsr_nxt = lfsr_step_c;
                    a_nxt    = lfsr_step_c[15:8];
                    b_nxt    = lfsr_step_c[7:0];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        pass_nxt = (state_nxt == DONE) && (err_nxt == 8'h00);
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= SEED;
            a           <= '0;
            b           <= '0;
            vec_count   <= '0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state       <= state_nxt;
            lfsr        <= lfsr_nxt;
            a           <= a_nxt;
            b           <= b_nxt;
            vec_count   <= vec_nxt;
            err_count   <= err_nxt;
            first_err_a <= fea_nxt;
            first_err_b <= feb_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            pass        <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_compare8_checker.sv
// Scoreboard bench for compare8_checker: a default-size instance driven by a
// switchable comparator model, and a 300-vector instance with all results tied high.
module tb_compare8_checker;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    logic start, start_l;
    int   mode;

    logic [7:0]  a, b, fea, feb;
    logic        re, reb, eq, busy, done, pass;
    logic [15:0] vec_count;
    logic [7:0]  err_count;

    logic [7:0]  a_l, b_l, fea_l, feb_l;
    logic        busy_l, done_l, pass_l;
    logic [15:0] vec_count_l;
    logic [7:0]  err_count_l;

    int checks = 0;
    int errors = 0;
    vec_t q[$];

    always #5 clock = ~clock;

    // Comparator model: 0 golden, 1 eq stuck at 0, 2 all outputs stuck at 1
    always_comb begin
        re  = (a > b);
        reb = (a < b);
        eq  = (a == b);
        if (mode == 1) eq = 1'b0;
        if (mode == 2) begin
            re = 1'b1; reb = 1'b1; eq = 1'b1;
        end
    end

    compare8_checker dut (
        .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
        .re(re), .reb(reb), .eq(eq), .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .first_err_a(fea), .first_err_b(feb)
    );

    compare8_checker #(.NUM_VECTORS(300)) dut_l (
        .clock(clock), .reset(reset), .start(start_l), .a(a_l), .b(b_l),
        .re(1'b1), .reb(1'b1), .eq(1'b1), .busy(busy_l), .done(done_l), .pass(pass_l),
        .vec_count(vec_count_l), .err_count(err_count_l),
        .first_err_a(fea_l), .first_err_b(feb_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    function automatic logic model_fails(input vec_t v, input int m);
        logic [2:0] g;
        logic [2:0] o;
        g = {v.a > v.b, v.a < v.b, v.a == v.b};
        o = g;
        if (m == 1) o[0] = 1'b0;
        if (m == 2) o = 3'b111;
        return (o != g);
    endfunction

    // One run of the default instance; optional extra start pulse at cycle extra_at
    task automatic run_short(input int m, input int extra_at);
        logic [15:0] l;
        vec_t        v, last;
        int          exp_err, cyc;
        logic [7:0]  exp_fa, exp_fb;
        mode    = m;
        l       = 16'hACE1;
        exp_err = 0;
        exp_fa  = 8'h00;
        exp_fb  = 8'h00;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                v.a = l[15:8]; v.b = l[15:8];
            end else begin
                l = lfsr_next(l);
                v.a = l[15:8]; v.b = l[7:0];
            end
            if (model_fails(v, m)) begin
                if (exp_err == 0) begin
                    exp_fa = v.a; exp_fb = v.b;
                end
                if (exp_err < 255) exp_err++;
            end
            q.push_back(v);
            last = v;
        end
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            start = (cyc == extra_at);
            if (busy && q.size() > 0) begin
                v = q.pop_front();
                check("vec_a", 32'(a), 32'(v.a));
                check("vec_b", 32'(b), 32'(v.b));
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", 32'(cyc), 32'd17);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("vec_count", 32'(vec_count), 32'd16);
        check("err_count", 32'(err_count), 32'(exp_err));
        check("pass", 32'(pass), 32'(exp_err == 0));
        check("first_err_a", 32'(fea), 32'(exp_fa));
        check("first_err_b", 32'(feb), 32'(exp_fb));
        check("busy_in_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        check("hold_a", 32'(a), 32'(last.a));
        check("hold_b", 32'(b), 32'(last.b));
        check("hold_done", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] l;
        int          cyc;
        reset   = 1'b1;
        start   = 1'b0;
        start_l = 1'b0;
        mode    = 0;
        #1;
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        check("rst_flags", 32'({busy, done, pass}), 32'd0);
        check("rst_vec", 32'(vec_count), 32'd0);
        @(negedge clock) reset = 1'b0;

        run_short(0, 0);
        run_short(1, 0);
        run_short(2, 0);
        run_short(0, 0);
        // second pulse lands mid-run and must be ignored
        run_short(0, 6);

        // reset in the middle of a run
        mode = 0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_reset_vec", 32'(vec_count), 32'd4);
        reset = 1'b1;
        #1;
        check("mid_rst_a", 32'(a), 32'd0);
        check("mid_rst_b", 32'(b), 32'd0);
        check("mid_rst_vec", 32'(vec_count), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_flags", 32'({busy, done, pass}), 32'd0);
        repeat (2) @(negedge clock);
        check("no_done_in_reset", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_reset", 32'({busy, done}), 32'd0);
        run_short(0, 0);

        // 300-vector run with every result wrong: error count saturates
        @(negedge clock) start_l = 1'b1;
        @(negedge clock) start_l = 1'b0;
        cyc = 1;
        while (!done_l && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        l = 16'hACE1;
        for (int i = 1; i < 300; i++) l = lfsr_next(l);
        check("long_latency", 32'(cyc), 32'd301);
        check("long_vec", 32'(vec_count_l), 32'd300);
        check("long_err_sat", 32'(err_count_l), 32'hFF);
        check("long_pass", 32'(pass_l), 32'd0);
        check("long_fea", 32'(fea_l), 32'hAC);
        check("long_feb", 32'(feb_l), 32'hAC);
        check("long_last_a", 32'(a_l), 32'(l[15:8]));
        check("long_last_b", 32'(b_l), 32'(l[7:0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
